bcsa_pipe: RTL and testbench
============================

// Module: bcsa_pipe
// PURPOSE
//  Parametrised, pipelined block carry-speculative adder (BCSA) with error detection.
//  - WIDTH-bit operands, split into NBLK = WIDTH/BLK blocks.
//  - Each block's carry-in is speculated from the previous block only.
//  - Sits in the approximate-arithmetic datapath behind a valid/ready stream.
//  - Reports speculation errors and keeps a saturating error count for accuracy profiling.
// PARAMETERS
//  WIDTH  16  operand width; must be a multiple of BLK
//  BLK    4   bits per speculation block; NBLK = WIDTH/BLK, NBLK >= 2
//  CNT_W  16  width of the error counter
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block can accept an operand pair
//  a          in   WIDTH    operand A (unsigned)
//  b          in   WIDTH    operand B (unsigned)
//  out_valid  out  1        result valid
//  out_ready  in   1        downstream accepts result
//  sum        out  WIDTH+1  result; MSB is carry-out
//  err        out  1        result differs from exact a+b (qualified by out_valid)
//  clr_cnt    in   1        synchronous clear of err_cnt
//  err_cnt    out  CNT_W    saturating count of delivered results with err=1
// BEHAVIOUR
//  Reset behaviour: one clk; rst is asynchronous and active-high. Reset clears:
//   - stage valids, so out_valid=0
//   - sum, err and err_cnt to 0
//   - FSM to RUN
//   - in_ready goes to 1 after reset deasserts
//  Speculation, per bit j: p=a^b, g=a&b, k=~a&~b.
//   - C0 = 0, the exact carry into block 0.
//   - Block i (i>=1) carry-in: ci = sel ? g[top(i-1)] : lc(i-1).
//   - lc(i-1) = carry-out of block i-1 computed with carry-in 0.
//   - sel = g[top(i-1)] | k[lsb(i)]; top/lsb are block MSB/LSB bit indices.
//   - Each block does a carry-lookahead sum with its ci; sum[WIDTH] = last block carry-out.
//   - exact = a+b (WIDTH+1 bits); err = (approx != exact).
//  Pipeline:
//   - S1 registers a,b on in_valid&&in_ready.
//   - S2 registers approx, exact and err computed from S1.
//   - out_valid comes from S2. Latency is 2 clk from accept to out_valid, no stall.
//   - Throughput is 1/clk.
//  Handshake:
//   - S2 advances when !s2_valid | out_ready.
//   - in_ready = (!s1_valid | S2 advances) & state==RUN.
//   - While out_valid & !out_ready, sum and err are held stable.
//   - Simultaneous accept and deliver in the same cycle is legal, with no bubble.
//  Counter:
//   - err_cnt += 1 on each out_valid&out_ready&err; holds at 2^CNT_W-1.
//   - clr_cnt has priority over an increment in the same cycle; the result is 0.
//  Reset mid-operation drops all in-flight results; none is delivered after reset.
// CONFIGURATION
//  Macro BCSA_CORRECT_EN.
//  Defined:
//   - FSM states RUN and FIX.
//   - RUN->FIX when S2 loads a result with err=1. out_valid=0 and in_ready=0 for
//     exactly 1 clk.
//   - FIX->RUN unconditionally. S2 then presents sum=exact, err=1.
//   - Erroneous ops have latency 3 clk. Ordering is preserved. err_cnt counts these.
//  Undefined:
//   - No FIX state. sum=approx always; err only flags the error.
// TESTING
//  (all tests WIDTH=16, BLK=4)
//  1. a=16'h1234, b=16'h4321, out_ready=1 -> sum=17'h05555, err=0, out_valid 2 clk after accept.
//  2. a=16'h00FF, b=16'h0001:
//     - without macro -> sum=17'h00000, err=1.
//     - with BCSA_CORRECT_EN -> 1-clk bubble, then sum=17'h00100, err=1.
//     - err_cnt=1 in both cases.
//  3. Back-to-back 8 ops, out_ready toggling every clk -> no loss or duplication,
//     sum stable while stalled, order kept.
//  4. a=16'hFFFF, b=16'hFFFF -> sum=17'h1FFFE, err=0; exercises carry-out in MSB.
//  5. err_cnt with CNT_W=2, 5 erroneous ops -> err_cnt=3 (saturated).
//     clr_cnt asserted with an error delivery in the same cycle -> err_cnt=0.
//  6. Assert rst with 2 ops in flight -> out_valid=0 immediately, err_cnt=0.
//     After release, a new op completes normally.

Source files
------------

// File: rtl/bcsa_pipe.sv
// Pipelined block carry-speculative adder with speculation-error flag and saturating error count.
// Optional macro BCSA_CORRECT_EN adds a one-cycle FIX state that replaces erroneous sums with the exact sum.
module bcsa_pipe #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int NBLK = WIDTH / BLK;

`ifdef BCSA_CORRECT_EN
    typedef enum logic [0:0] {RUN = 1'b0, FIX = 1'b1} state_t;
`else
    typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

    state_t           state_q, state_d;
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   sum_q, sum_d;
    logic             err_q, err_d;
`ifdef BCSA_CORRECT_EN
    logic [WIDTH:0]   exact_q, exact_d;
`endif
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] p_s, g_s;
    logic [NBLK-1:0]  ci_s;
    logic [WIDTH:0]   approx_s, exact_s;
    logic             err_s, lc_s, c_s;
    logic             run_s, s2_adv_s, s2_load_s, accept_s, deliver_s, in_ready_s;

    // Speculative carry selection per block, then in-block lookahead sum.
    always_comb begin
        p_s      = s1_a_q ^ s1_b_q;
        g_s      = s1_a_q & s1_b_q;
        ci_s     = '0;
        approx_s = '0;
        lc_s     = 1'b0;
        c_s      = 1'b0;
        for (int i = 1; i < NBLK; i++) begin
            lc_s = 1'b0;
            for (int j = 0; j < BLK; j++) begin
                lc_s = g_s[(i-1)*BLK+j] | (p_s[(i-1)*BLK+j] & lc_s);
            end
            // A generate at the previous top bit or a kill at this LSB decides the carry locally.
            if (g_s[i*BLK-1] | (~s1_a_q[i*BLK] & ~s1_b_q[i*BLK])) begin
                ci_s[i] = g_s[i*BLK-1];
            end else begin
                ci_s[i] = lc_s;
            end
        end
        for (int i = 0; i < NBLK; i++) begin
            c_s = ci_s[i];
            for (int j = 0; j < BLK; j++) begin
                approx_s[i*BLK+j] = p_s[i*BLK+j] ^ c_s;
                c_s = g_s[i*BLK+j] | (p_s[i*BLK+j] & c_s);
            end
        end
        approx_s[WIDTH] = c_s;
        exact_s = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        err_s   = (approx_s != exact_s);
    end

    // Handshake qualifiers shared by both stages, FSM and counter.
    always_comb begin
        run_s      = (state_q == RUN);
        s2_adv_s   = (~s2_valid_q | out_ready) & run_s;
        s2_load_s  = s2_adv_s & s1_valid_q;
        in_ready_s = (~s1_valid_q | s2_adv_s) & run_s;
        accept_s   = in_valid & in_ready_s;
        deliver_s  = s2_valid_q & run_s & out_ready;
    end

    // Next-state for the correction FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
`ifdef BCSA_CORRECT_EN
                if (s2_load_s && err_s) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
`else
                state_d = RUN;
`endif
            end
`ifdef BCSA_CORRECT_EN
            FIX:     state_d = RUN;
`endif
            default: state_d = RUN;
        endcase
    end

    // Stage 1 operand capture.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        if (accept_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
        end else if (s2_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 result capture; in FIX the held sum is overwritten by the exact sum.
    always_comb begin
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        err_d      = err_q;
`ifdef BCSA_CORRECT_EN
        exact_d    = exact_q;
`endif
        if (s2_load_s) begin
            s2_valid_d = 1'b1;
            sum_d      = approx_s;
            err_d      = err_s;
`ifdef BCSA_CORRECT_EN
            exact_d    = exact_s;
`endif
        end else if (s2_adv_s) begin
            s2_valid_d = 1'b0;
`ifdef BCSA_CORRECT_EN
        end else if (state_q == FIX) begin
            sum_d      = exact_q;
`endif
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Saturating error counter; clear wins over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (deliver_s && err_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            s1_valid_q <= 1'b0;
            s1_a_q     <= {WIDTH{1'b0}};
            s1_b_q     <= {WIDTH{1'b0}};
            s2_valid_q <= 1'b0;
            sum_q      <= {(WIDTH+1){1'b0}};
            err_q      <= 1'b0;
`ifdef BCSA_CORRECT_EN
            exact_q    <= {(WIDTH+1){1'b0}};
`endif
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            err_q      <= err_d;
`ifdef BCSA_CORRECT_EN
            exact_q    <= exact_d;
`endif
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q & run_s;
    assign sum       = sum_q;
    assign err       = err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_bcsa_pipe.sv
// Self-checking bench for bcsa_pipe: directed table, handshake sequences, randomized traffic
// against an arithmetic reference model, counter saturation and mid-flight reset.
module tb_bcsa_pipe;
    localparam int WIDTH = 16;
    localparam int BLK   = 4;
    localparam int NBLK  = WIDTH / BLK;
`ifdef BCSA_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, in_valid, out_ready, clr_cnt;
    logic [WIDTH-1:0]  a, b;
    logic              in_ready, out_valid, err;
    logic [WIDTH:0]    sum;
    logic [15:0]       err_cnt;
    logic              in_ready2, out_valid2, err2;
    logic [WIDTH:0]    sum2;
    logic [1:0]        err_cnt2;

    int errors = 0;
    int checks = 0;
    int or_mode = 0;
    int mcnt = 0;
    int mcnt2 = 0;

    typedef struct {
        logic [WIDTH:0] s;
        logic           e;
    } res_t;
    res_t q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0]   approx;
        logic [WIDTH:0]   exact;
        logic             e;
    } vec_t;
    vec_t tbl[7];

    always #5 clk = ~clk;

    bcsa_pipe #(.WIDTH(WIDTH), .BLK(BLK), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .err(err),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt));

    bcsa_pipe #(.WIDTH(WIDTH), .BLK(BLK), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b),
        .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .err(err2),
        .clr_cnt(clr_cnt), .err_cnt(err_cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Block-speculative sum derived directly from the carry-selection rules.
    function automatic logic [WIDTH:0] spec_approx(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] g, k;
        int mask, xi, yi, px, py, c, s;
        mask = (1 << BLK) - 1;
        g = x & y;
        k = ~x & ~y;
        r = '0;
        c = 0;
        for (int i = 0; i < NBLK; i++) begin
            xi = int'(x >> (i*BLK)) & mask;
            yi = int'(y >> (i*BLK)) & mask;
            if (i == 0) begin
                c = 0;
            end else begin
                px = int'(x >> ((i-1)*BLK)) & mask;
                py = int'(y >> ((i-1)*BLK)) & mask;
                if (g[i*BLK-1] || k[i*BLK]) c = int'(g[i*BLK-1]);
                else c = (px + py) >> BLK;
            end
            s = xi + yi + c;
            r = r | ((WIDTH+1)'(s & mask) << (i*BLK));
            if (i == NBLK-1) r[WIDTH] = ((s >> BLK) != 0);
        end
        return r;
    endfunction

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        res_t r;
        logic [WIDTH:0] ap, ex;
        ap = spec_approx(x, y);
        ex = {1'b0, x} + {1'b0, y};
        r.e = (ap != ex);
        r.s = (CORR && r.e) ? ex : ap;
        return r;
    endfunction

    // Scoreboard: checks counters and delivered results, then books accepts.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mcnt  = 0;
            mcnt2 = 0;
        end else begin
            chk("err_cnt", err_cnt, mcnt);
            chk("err_cnt_w2", err_cnt2, mcnt2);
            chk("in_ready_w2", in_ready2, in_ready);
            if (out_valid || out_valid2) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: out_valid=1 sum=%0h with nothing outstanding", sum);
                end else begin
                    chk("sb_valid", out_valid, 1);
                    chk("sb_valid_w2", out_valid2, 1);
                    chk("sb_sum", sum, q[0].s);
                    chk("sb_err", err, q[0].e);
                    chk("sb_sum_w2", sum2, q[0].s);
                    chk("sb_err_w2", err2, q[0].e);
                    if (out_ready) begin
                        if (q[0].e) begin
                            if (mcnt < 65535) mcnt++;
                            if (mcnt2 < 3) mcnt2++;
                        end
                        void'(q.pop_front());
                    end
                end
            end
            if (clr_cnt) begin
                mcnt  = 0;
                mcnt2 = 0;
            end
            if (in_valid && in_ready) q.push_back(model(a, b));
        end
    end

    // Downstream ready pattern.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stuck at 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, lat;
        logic [WIDTH-1:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; clr_cnt = 1'b0; a = '0; b = '0;

        tbl[0] = '{16'h1234, 16'h4321, 17'h05555, 17'h05555, 1'b0};
        tbl[1] = '{16'h00FF, 16'h0001, 17'h00000, 17'h00100, 1'b1};
        tbl[2] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE, 17'h1FFFE, 1'b0};
        tbl[3] = '{16'h0000, 16'h0000, 17'h00000, 17'h00000, 1'b0};
        tbl[4] = '{16'hFFFF, 16'h0001, 17'h0FF00, 17'h10000, 1'b1};
        tbl[5] = '{16'h000F, 16'h0001, 17'h00000, 17'h00010, 1'b1};
        tbl[6] = '{16'h0888, 16'h0888, 17'h01110, 17'h01110, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed vectors with latency measured from the accept cycle.
        for (int t = 0; t < 7; t++) begin
            or_mode = 0;
            send(tbl[t].a, tbl[t].b);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!out_valid && n < 10);
            lat = (CORR && tbl[t].e) ? 3 : 2;
            chk("tbl_latency", n, lat);
            chk("tbl_sum", sum, (CORR && tbl[t].e) ? tbl[t].exact : tbl[t].approx);
            chk("tbl_err", err, tbl[t].e);
            @(posedge clk);
            #1;
        end
        drain();
        chk("tbl_err_cnt", err_cnt, 3);

        // Back-to-back ops with out_ready toggling every clock.
        or_mode = 1;
        for (int t = 0; t < 8; t++) send(16'($urandom), 16'($urandom));
        drain();

        // Randomized traffic with gaps and random backpressure.
        or_mode = 2;
        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = 16'($urandom);
                1:       rb = ~ra ^ 16'(1 << $urandom_range(0, 15));
                default: rb = 16'($urandom_range(0, 15));
            endcase
            send(ra, rb);
        end
        drain();

        // Counter saturation on the narrow instance.
        or_mode = 0;
        for (int t = 0; t < 5; t++) send(16'h00FF, 16'h0001);
        drain();
        chk("cnt_w2_saturated", err_cnt2, 3);

        // Clear in the same cycle as an erroneous delivery.
        send(16'h00FF, 16'h0001);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("clr_setup_valid", out_valid, 1);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_err_cnt_w2", err_cnt2, 0);
        drain();

        // Reset with two results in flight.
        send(16'h000F, 16'h0001);
        drain();
        send(16'h1234, 16'h4321);
        send(16'h0888, 16'h0888);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        chk("midrst_sum", sum, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_in_ready", in_ready, 1);
        chk("postrst_out_valid", out_valid, 0);
        send(16'h1234, 16'h4321);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
        chk("postrst_latency", n, 2);
        chk("postrst_sum", sum, 17'h05555);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
